// File: rtl/bias_relu_writeback_pkg.sv
// Shared types and constants for the bias/ReLU/writeback stage.
// Optional feature macro: ADDR_CHECK_EN (see bias_relu_writeback.sv).
package bias_relu_writeback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Element counter width; m*n of two 10-bit dimensions fits in 20 bits.
    localparam int CNT_W = 20;
    // Width of the m/n dimension ports and the bias address.
    localparam int DIM_W = 10;

    // Largest signed value representable in out_w bits.
    function automatic logic signed [63:0] sat_hi(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in out_w bits.
    function automatic logic signed [63:0] sat_lo(input int out_w);
        return -(64'sd1 <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/bias_relu_writeback_sat_shift.sv
// Combinational bias add, optional ReLU, arithmetic right shift and
// saturation to OUT_W bits. The add is one bit wider than DATA_W so it
// can never wrap.
module bias_relu_writeback_sat_shift
    import bias_relu_writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0,
    parameter int RELU   = 1
) (
    input  logic signed [DATA_W-1:0] data_i,
    input  logic signed [DATA_W-1:0] bias_i,
    output logic signed [OUT_W-1:0]  res_o
);

    localparam logic signed [63:0]     HI64 = sat_hi(OUT_W);
    localparam logic signed [63:0]     LO64 = sat_lo(OUT_W);
    localparam logic signed [DATA_W:0] HI   = HI64[DATA_W:0];
    localparam logic signed [DATA_W:0] LO   = LO64[DATA_W:0];

    function automatic logic signed [DATA_W:0] relu_shift(input logic signed [DATA_W:0] s);
        logic signed [DATA_W:0] r;
        r = s;
        if (RELU != 0 && r[DATA_W]) r = '0;
        return r >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [DATA_W:0] s);
        if (s > HI)      return HI[OUT_W-1:0];
        else if (s < LO) return LO[OUT_W-1:0];
        else             return s[OUT_W-1:0];
    endfunction

    logic signed [DATA_W:0] sum;

    assign sum   = {data_i[DATA_W-1], data_i} + {bias_i[DATA_W-1], bias_i};
    assign res_o = saturate(relu_shift(sum));

endmodule

// File: rtl/bias_relu_writeback.sv
// Post-matmul writeback: adds a per-column bias, applies ReLU/shift/saturate
// and writes the activation. Two-stage pipeline, one element per cycle.
// Optional feature macro: ADDR_CHECK_EN adds a sticky err output flagging
// any accepted in_addr that is not the expected row-major index.
module bias_relu_writeback
    import bias_relu_writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 16,
    parameter int SHIFT  = 0,
    parameter int RELU   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DIM_W-1:0]         m,
    input  logic [DIM_W-1:0]         n,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic signed [DATA_W-1:0] in_data,
    output logic [DIM_W-1:0]         bias_addr,
    input  logic signed [DATA_W-1:0] bias_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_we,
    output logic                     busy,
    output logic                     done
`ifdef ADDR_CHECK_EN
    ,
    output logic                     err
`endif
);

    state_t                   state_q;
    logic [CNT_W-1:0]         mn_q, cnt_q, cnt_d;
    logic [DIM_W-1:0]         n_q, col_q, col_d;
    logic                     busy_q, done_q;
    logic                     accept;

    logic                     vld_p0_q;
    logic [ADDR_W-1:0]        addr_p0_q;
    logic signed [DATA_W-1:0] data_p0_q;

    logic                     vld_p1_q;
    logic [ADDR_W-1:0]        out_addr_p1_q;
    logic signed [OUT_W-1:0]  out_data_p1_q;
    logic signed [OUT_W-1:0]  sat_res;

    // Accept an element only while running and short of m*n; advance column with wrap.
    always_comb begin
        accept = in_valid && (state_q == RUN) && (cnt_q != mn_q);
        cnt_d  = cnt_q;
        col_d  = col_q;
        if (accept) begin
            cnt_d = cnt_q + 1'b1;
            col_d = (col_q == n_q - 1'b1) ? '0 : col_q + 1'b1;
        end
    end

    // Control FSM, counters and stage-0 valid; start restarts from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mn_q     <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_p0_q <= 1'b0;
        end else if (start) begin
            state_q  <= RUN;
            mn_q     <= CNT_W'(m) * CNT_W'(n);
            n_q      <= n;
            cnt_q    <= '0;
            col_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            vld_p0_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            vld_p0_q <= accept;
            done_q   <= 1'b0;
            case (state_q)
                IDLE:  busy_q <= 1'b0;
                RUN:   if (cnt_q == mn_q) state_q <= DRAIN;
                DRAIN: if (!vld_p0_q && !vld_p1_q) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---- stage 0: capture accepted element; bias read issued from col_q ----
    // Capture address and data of the accepted element.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0_q <= in_addr;
            data_p0_q <= in_data;
        end
    end

    // ---- stage 1: bias add / ReLU / shift / saturate, register write ----
    bias_relu_writeback_sat_shift #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .RELU   (RELU)
    ) u_sat_shift (
        .data_i (data_p0_q),
        .bias_i (bias_data),
        .res_o  (sat_res)
    );

    // Register the write; a restart drops whatever sits in stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q      <= 1'b0;
            out_addr_p1_q <= '0;
            out_data_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_p0_q && !start;
            if (vld_p0_q && !start) begin
                out_addr_p1_q <= addr_p0_q;
                out_data_p1_q <= sat_res;
            end
        end
    end

`ifdef ADDR_CHECK_EN
    logic [ADDR_W-1:0] exp_q;
    logic              err_q;

    // Track expected row-major address; err stays set until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else if (start) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            exp_q <= exp_q + 1'b1;
            if (in_addr != exp_q) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    assign bias_addr = col_q;
    assign out_addr  = out_addr_p1_q;
    assign out_data  = out_data_p1_q;
    assign out_we    = vld_p1_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bias_relu_writeback.sv
// Directed bench for bias_relu_writeback: default instance (RELU=1,SHIFT=0)
// plus an instance with RELU=0, SHIFT=2, OUT_W=16. Writes are checked
// against a queue of expected (addr, data, cycle) entries.
module tb_bias_relu_writeback;

    typedef struct {
        logic [15:0]        addr;
        logic signed [31:0] data;
        int                 cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A (defaults)
    logic               a_start = 0, a_in_valid = 0;
    logic [9:0]         a_m = 0, a_n = 0, a_bias_addr;
    logic [15:0]        a_in_addr = 0, a_out_addr;
    logic signed [31:0] a_in_data = 0, a_bias_data, a_out_data;
    logic               a_out_we, a_busy, a_done;
    logic signed [31:0] a_bmem [0:1023];
    exp_t               qa[$];

    // instance B (RELU=0, SHIFT=2, OUT_W=16)
    logic               b_start = 0, b_in_valid = 0;
    logic [9:0]         b_m = 0, b_n = 0, b_bias_addr;
    logic [15:0]        b_in_addr = 0, b_out_addr;
    logic signed [31:0] b_in_data = 0, b_bias_data;
    logic signed [15:0] b_out_data;
    logic               b_out_we, b_busy, b_done;
    logic signed [31:0] b_bmem [0:1023];
    exp_t               qb[$];

`ifdef ADDR_CHECK_EN
    logic a_err, b_err;
`endif

    bias_relu_writeback dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .m(a_m), .n(a_n),
        .in_valid(a_in_valid), .in_addr(a_in_addr), .in_data(a_in_data),
        .bias_addr(a_bias_addr), .bias_data(a_bias_data),
        .out_addr(a_out_addr), .out_data(a_out_data), .out_we(a_out_we),
        .busy(a_busy), .done(a_done)
`ifdef ADDR_CHECK_EN
        , .err(a_err)
`endif
    );

    bias_relu_writeback #(.OUT_W(16), .SHIFT(2), .RELU(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .m(b_m), .n(b_n),
        .in_valid(b_in_valid), .in_addr(b_in_addr), .in_data(b_in_data),
        .bias_addr(b_bias_addr), .bias_data(b_bias_data),
        .out_addr(b_out_addr), .out_data(b_out_data), .out_we(b_out_we),
        .busy(b_busy), .done(b_done)
`ifdef ADDR_CHECK_EN
        , .err(b_err)
`endif
    );

    // synchronous-read bias memories, one cycle latency
    always @(posedge clk) begin
        a_bias_data <= a_bmem[a_bias_addr];
        b_bias_data <= b_bmem[b_bias_addr];
    end

    // write monitors: every strobe must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (a_out_we === 1'b1) begin
            nvec++;
            assert (qa.size() > 0) else begin
                nfail++;
                $error("FAIL a_unexpected_write observed addr=%0d data=%0d expected=no write", a_out_addr, a_out_data);
            end
            if (qa.size() > 0) begin
                e = qa.pop_front();
                nvec++;
                assert ({a_out_addr, a_out_data, cyc} === {e.addr, e.data, e.cyc}) else begin
                    nfail++;
                    $error("FAIL a_write observed addr=%0d data=%0d cyc=%0d expected addr=%0d data=%0d cyc=%0d",
                           a_out_addr, a_out_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (b_out_we === 1'b1) begin
            nvec++;
            assert (qb.size() > 0) else begin
                nfail++;
                $error("FAIL b_unexpected_write observed addr=%0d data=%0d expected=no write", b_out_addr, b_out_data);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                nvec++;
                assert ({b_out_addr, b_out_data, cyc} === {e.addr, e.data[15:0], e.cyc}) else begin
                    nfail++;
                    $error("FAIL b_write observed addr=%0d data=%0d cyc=%0d expected addr=%0d data=%0d cyc=%0d",
                           b_out_addr, b_out_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic a_go(input logic [9:0] mm, input logic [9:0] nn);
        a_m = mm; a_n = nn; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic b_go(input logic [9:0] mm, input logic [9:0] nn);
        b_m = mm; b_n = nn; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
    endtask

    // present one element for one cycle; optionally expect its write two cycles later
    task automatic a_elem(input logic [15:0] addr, input logic signed [31:0] d,
                          input logic signed [31:0] exp_v, input bit push);
        exp_t e;
        a_in_valid = 1'b1; a_in_addr = addr; a_in_data = d;
        if (push) begin
            e.addr = addr; e.data = exp_v; e.cyc = cyc + 2;
            qa.push_back(e);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_elem(input logic [15:0] addr, input logic signed [31:0] d,
                          input logic signed [31:0] exp_v);
        exp_t e;
        b_in_valid = 1'b1; b_in_addr = addr; b_in_data = d;
        e.addr = addr; e.data = exp_v; e.cyc = cyc + 2;
        qb.push_back(e);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    // bounded wait for done on A; checks single-cycle pulse and idle afterwards
    task automatic a_wait_done(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        nvec++;
        assert (at >= 0) else begin
            nfail++;
            $error("FAIL %s_done observed=no pulse expected=done pulse", tag);
        end
        if (at >= 0) begin
            @(negedge clk);
            chk({tag, "_done_width"}, a_done, 0);
            chk({tag, "_busy_after"}, a_busy, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, s;
        for (int i = 0; i < 1024; i++) begin
            a_bmem[i] = 0;
            b_bmem[i] = 0;
        end

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bias_addr", a_bias_addr, 0);
        chk("rst_out_addr", a_out_addr, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_we", a_out_we, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 2x3 back-to-back with ReLU
        a_bmem[0] = 10; a_bmem[1] = -5; a_bmem[2] = 0;
        a_go(2, 3);
        chk("t1_busy", a_busy, 1);
        a_elem(0, 1, 11, 1);
        a_elem(1, 2, 0, 1);
        a_elem(2, 3, 3, 1);
        a_elem(3, 4, 14, 1);
        a_elem(4, 5, 0, 1);
        a_elem(5, 6, 6, 1);
        a_wait_done("t1", at);
        chk("t1_queue_empty", qa.size(), 0);
`ifdef ADDR_CHECK_EN
        chk("t1_err", a_err, 0);
`endif

        // RELU=0, SHIFT=2, OUT_W=16: shift and both saturation rails
        b_bmem[0] = 0; b_bmem[1] = 1; b_bmem[2] = -1;
        b_go(1, 3);
        b_elem(0, -100, -25);
        b_elem(1, 32'sh7FFFFFFF, 32767);
        b_elem(2, 32'sh80000000, -32768);
        repeat (6) @(posedge clk);
        #1;
        chk("t2_queue_empty", qb.size(), 0);
        chk("t2_b_busy", b_busy, 0);

        // gapped input, 1x4: column walk, wrap, positive saturation at OUT_W=32
        a_bmem[0] = 1; a_bmem[1] = 2; a_bmem[2] = 3; a_bmem[3] = 4;
        a_go(1, 4);
        chk("gap_bias_addr0", a_bias_addr, 0);
        a_elem(0, 100, 101, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("gap_bias_addr1", a_bias_addr, 1);
        a_elem(1, -50, 0, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("gap_bias_addr2", a_bias_addr, 2);
        a_elem(2, 7, 10, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("gap_bias_addr3", a_bias_addr, 3);
        a_elem(3, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 1);
        chk("gap_col_wrap", a_bias_addr, 0);
        a_wait_done("gap", at);
        chk("gap_queue_empty", qa.size(), 0);

        // m=0: no writes, done exactly 3 cycles after start
        s = cyc;
        a_go(0, 5);
        a_wait_done("m0", at);
        chk("m0_done_cycle", at, s + 3);

        // restart during RUN: in-flight element dropped, counters restart
        a_bmem[0] = 10; a_bmem[1] = -5; a_bmem[2] = 0;
        a_go(2, 2);
        a_elem(0, 1, 11, 1);
        a_elem(1, 9, 0, 0);
        a_go(1, 2);
        chk("rs_bias_addr", a_bias_addr, 0);
        a_elem(0, 1, 11, 1);
        a_elem(1, 2, 0, 1);
        a_wait_done("rs", at);
        chk("rs_queue_empty", qa.size(), 0);

        // async reset mid-run in a 2x2 run
        a_go(2, 2);
        a_elem(4, 5, 15, 1);
        a_elem(5, 6, 0, 0);
        a_in_valid = 1'b1; a_in_addr = 6; a_in_data = 7;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_addr", a_out_addr, 0);
        chk("mrst_out_data", a_out_data, 0);
        chk("mrst_out_we", a_out_we, 0);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_done", a_done, 0);
        chk("mrst_bias_addr", a_bias_addr, 0);
`ifdef ADDR_CHECK_EN
        chk("mrst_err", a_err, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("mrst_idle_busy", a_busy, 0);
        a_in_valid = 1'b0;
        chk("mrst_queue_empty", qa.size(), 0);

`ifdef ADDR_CHECK_EN
        // address check: sequence 0,1,3 flags on the third element
        a_bmem[0] = 10; a_bmem[1] = -5; a_bmem[2] = 0;
        a_go(1, 3);
        a_elem(0, 1, 11, 1);
        a_elem(1, 2, 0, 1);
        chk("ac_err_clear", a_err, 0);
        a_elem(3, 3, 3, 1);
        chk("ac_err_rise", a_err, 1);
        a_wait_done("ac", at);
        chk("ac_err_sticky", a_err, 1);
        a_go(0, 1);
        chk("ac_err_start_clear", a_err, 0);
        a_wait_done("ac2", at);
        chk("ac_queue_empty", qa.size(), 0);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
